// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
// Arbitrates the single SDRAM burst-command port between the camera write
// path and the display read path. It tracks the write/read word offsets and
// ping-pong buffer selection, so the display always reads a complete frame
// while the camera fills the other buffer.
//
// Ports:
//   clk_100, rst_n            clock, async active-low reset
//   enable                    level, scheduler runs while high
//   frame_start               1-cycle pulse, restarts the write offset
//   cam_count, disp_count     camera / display FIFO fill levels
//   cmd_valid/ready/rw/addr   burst command handshake (rw: 1 = write)
//   burst_done                1-cycle pulse, accepted burst finished
//   wr_buf, rd_buf            buffer being written / displayed
//   frame_valid               sticky, a complete frame exists
//   overflow_err              sticky, camera FIFO seen full (1023)
//
// state    | meaning
// S_IDLE   | scheduler parked, waiting for enable
// S_ARB    | sample FIFO levels, grant one requester
// S_ISSUE  | cmd_valid high until cmd_ready
// S_BUSY   | burst in progress, wait for burst_done
// S_UPDATE | advance pointers / buffer selection
module frame_buffer_scheduler #(
  parameter int ADDR_W      = 20,
  parameter int BURST_LEN   = 512,
  parameter int FRAME_WORDS = 307200,
  parameter int BUF_STRIDE  = 524288,
  parameter int DISP_LOW    = 512,
  parameter int DISP_CRIT   = 128
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [9:0]        cam_count,
  input  logic [9:0]        disp_count,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              burst_done,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic              frame_valid,
  output logic              overflow_err
);

  localparam int OFS_W = $clog2(FRAME_WORDS + 1);
  localparam logic [10:0]       BURST_LVL = 11'(BURST_LEN);
  localparam logic [10:0]       LOW_LVL   = 11'(DISP_LOW);
  localparam logic [10:0]       CRIT_LVL  = 11'(DISP_CRIT);
  localparam logic [OFS_W-1:0]  BURST_OFS = OFS_W'(BURST_LEN);
  localparam logic [OFS_W-1:0]  FRAME_OFS = OFS_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(BUF_STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_BUSY, S_UPDATE} state_t;

  state_t            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_rw_q, cmd_rw_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_buf_q, wr_buf_d;
  logic              rd_buf_q, rd_buf_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overflow_err_q, overflow_err_d;
  logic              pending_q, pending_d;
  logic              resync_q, resync_d;
  logic [OFS_W-1:0]  wr_ofs_q, wr_ofs_d;
  logic [OFS_W-1:0]  rd_ofs_q, rd_ofs_d;

  logic              cam_req, disp_req, disp_crit, resync_now;
  logic [OFS_W-1:0]  wr_ofs_eff, wr_ofs_nxt, rd_ofs_nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign cam_req    = ({1'b0, cam_count} >= BURST_LVL);
  assign disp_req   = frame_valid_q && ({1'b0, disp_count} <= LOW_LVL);
  assign disp_crit  = ({1'b0, disp_count} < CRIT_LVL);
  // A frame_start arriving in the same cycle acts as an already-pending resync.
  assign resync_now = resync_q | frame_start;
  // A write granted in the cycle the resync lands must already start at 0.
  assign wr_ofs_eff = resync_now ? '0 : wr_ofs_q;
  assign wr_ofs_nxt = wr_ofs_q + BURST_OFS;
  assign rd_ofs_nxt = rd_ofs_q + BURST_OFS;
  assign wr_addr    = (wr_buf_q ? STRIDE_A : '0) + ADDR_W'(wr_ofs_eff);
  assign rd_addr    = (rd_buf_q ? STRIDE_A : '0) + ADDR_W'(rd_ofs_q);

  always_comb begin
    state_d        = state_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_rw_d       = cmd_rw_q;
    cmd_addr_d     = cmd_addr_q;
    wr_buf_d       = wr_buf_q;
    rd_buf_d       = rd_buf_q;
    frame_valid_d  = frame_valid_q;
    pending_d      = pending_q;
    wr_ofs_d       = wr_ofs_q;
    rd_ofs_d       = rd_ofs_q;
    resync_d       = resync_q | frame_start;
    overflow_err_d = overflow_err_q | (cam_count == 10'h3FF);
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_ARB;
      S_ARB: begin
        // No burst is in flight here, so a pending resync applies at once.
        if (resync_now) begin
          wr_ofs_d = '0;
          resync_d = 1'b0;
        end
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cam_req || disp_req) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          if (disp_req && (!cam_req || disp_crit)) begin
            cmd_rw_d   = 1'b0;
            cmd_addr_d = rd_addr;
          end else begin
            cmd_rw_d   = 1'b1;
            cmd_addr_d = wr_addr;
          end
        end
      end
      S_ISSUE: if (cmd_ready) begin
        cmd_valid_d = 1'b0;
        state_d     = S_BUSY;
      end
      S_BUSY: if (burst_done) state_d = S_UPDATE;
      S_UPDATE: begin
        state_d = enable ? S_ARB : S_IDLE;
        if (resync_now) begin
          wr_ofs_d = '0;
          resync_d = 1'b0;
        end
        if (cmd_rw_q) begin
          if (wr_ofs_nxt == FRAME_OFS) begin
            // Completion wins over a coincident resync.
            wr_ofs_d      = '0;
            wr_buf_d      = ~wr_buf_q;
            pending_d     = 1'b1;
            frame_valid_d = 1'b1;
          end else if (!resync_now) begin
            wr_ofs_d = wr_ofs_nxt;
          end
        end else if (rd_ofs_nxt == FRAME_OFS) begin
          rd_ofs_d = '0;
          if (pending_q) begin
            rd_buf_d  = ~wr_buf_q;
            pending_d = 1'b0;
          end
        end else begin
          rd_ofs_d = rd_ofs_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_rw_q       <= 1'b0;
      cmd_addr_q     <= '0;
      wr_buf_q       <= 1'b0;
      rd_buf_q       <= 1'b0;
      frame_valid_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      pending_q      <= 1'b0;
      resync_q       <= 1'b0;
      wr_ofs_q       <= '0;
      rd_ofs_q       <= '0;
    end else begin
      state_q        <= state_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_rw_q       <= cmd_rw_d;
      cmd_addr_q     <= cmd_addr_d;
      wr_buf_q       <= wr_buf_d;
      rd_buf_q       <= rd_buf_d;
      frame_valid_q  <= frame_valid_d;
      overflow_err_q <= overflow_err_d;
      pending_q      <= pending_d;
      resync_q       <= resync_d;
      wr_ofs_q       <= wr_ofs_d;
      rd_ofs_q       <= rd_ofs_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_rw       = cmd_rw_q;
  assign cmd_addr     = cmd_addr_q;
  assign wr_buf       = wr_buf_q;
  assign rd_buf       = rd_buf_q;
  assign frame_valid  = frame_valid_q;
  assign overflow_err = overflow_err_q;

endmodule
